pipe_stage_chain: RTL

Parametrised elastic pipeline register chain that replaces fixed, enable-only stage registers in the pipelined core.
- STAGES back-to-back registers, each with its own valid bit.
- valid/ready handshake at both ends.
- Per-stage flush for branch/jump squash.
- Bubble collapsing, so an empty stage never blocks upstream data.
- Occupancy report.
- Target users: IF/ID, ID/EX, EX/MEM and MEM/WB stage registers with stall/flush support, plus generic buffering between the core and memories.

---
 rtl/pipe_stage_chain.sv | 54 +++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with per-stage flush, bubble collapsing, occupancy and optional stall counter (PIPE_STAGE_CHAIN_PERF_EN)
module pipe_stage_chain #(
  parameter int DATA_W = 64,
  parameter int STAGES = 4,
  localparam int CNT_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [STAGES-1:0] flush,
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [CNT_W-1:0]  occupancy
);
  logic [STAGES-1:0] v, rdy, sv;
  logic [DATA_W-1:0] d [STAGES];
  logic [DATA_W-1:0] sd [STAGES];
  assign sv[0] = in_valid;
  assign sd[0] = in_data;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k > 0) begin : g_src
      assign sv[k] = v[k-1];
      assign sd[k] = d[k-1];
    end
    assign rdy[k] = out_ready | ~&v[STAGES-1:k];
    always_ff @(posedge clk or posedge arst)
      if (arst) begin
        v[k] <= 1'b0;
        d[k] <= '0;
      end else if (flush[k]) v[k] <= 1'b0;
      else if (rdy[k]) begin
        v[k] <= sv[k];
        if (sv[k]) d[k] <= sd[k];
      end
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + CNT_W'(v[i]);
  end
  assign in_ready = rdy[0];
  assign out_valid = v[STAGES-1];
  assign out_data = d[STAGES-1];
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  always_ff @(posedge clk or posedge arst)
    if (arst) stall_cnt <= '0;
    else if (out_valid && !out_ready && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule
